// File: rtl/line_collision_checker.sv
`default_nettype none
// ============================================================================
// Module   : line_collision_checker
// Purpose  : Walks every grid cell on the straight segment between two cell
//            coordinates using integer Bresenham stepping. Each cell is
//            queried once on the occupancy-grid read port, and the result
//            reports whether any visited cell is occupied. Used by the RRT
//            extend step to validate a candidate edge before it is committed.
// Revision : 1.0 - initial release
//
// Build option:
//   LINE_CHECK_EARLY_EXIT_EN - when defined, the walk stops at the first
//                              occupied cell. In that case cells_checked is
//                              the index of that cell plus one. When not
//                              defined, the whole segment is always walked.
//
// Ports:
//   clk            in   clock, all logic on the rising edge
//   rst_n          in   asynchronous active-low reset
//   req_vld        in   segment request valid
//   req_rdy        out  checker idle and able to accept a request
//   x0_in, x1_in   in   segment start/end x             [W-1:0]
//   y0_in, y1_in   in   segment start/end y             [H-1:0]
//   res_vld        out  result valid, held until res_rdy
//   res_rdy        in   consumer accepts result
//   collision      out  1 = at least one visited cell occupied
//   cells_checked  out  grid queries completed          [max(W,H):0]
//   cell_x_out     out  query cell x to grid            [W-1:0]
//   cell_y_out     out  query cell y to grid            [H-1:0]
//   grid_vld       out  query valid to grid
//   grid_we        out  grid write enable, always 0
//   grid_rdy       in   grid can accept a query
//   grid_res_vld   in   grid response valid
//   grid_occupied  in   grid response: cell occupied
// ============================================================================
module line_collision_checker #(
    parameter int GRID_WIDTH_LOG2  = 8,
    parameter int GRID_HEIGHT_LOG2 = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   req_vld,
    output logic                                   req_rdy,
    input  logic [GRID_WIDTH_LOG2-1:0]             x0_in,
    input  logic [GRID_HEIGHT_LOG2-1:0]            y0_in,
    input  logic [GRID_WIDTH_LOG2-1:0]             x1_in,
    input  logic [GRID_HEIGHT_LOG2-1:0]            y1_in,
    output logic                                   res_vld,
    input  logic                                   res_rdy,
    output logic                                   collision,
    output logic [((GRID_WIDTH_LOG2 > GRID_HEIGHT_LOG2) ?
                   GRID_WIDTH_LOG2 : GRID_HEIGHT_LOG2):0] cells_checked,
    output logic [GRID_WIDTH_LOG2-1:0]             cell_x_out,
    output logic [GRID_HEIGHT_LOG2-1:0]            cell_y_out,
    output logic                                   grid_vld,
    output logic                                   grid_we,
    input  logic                                   grid_rdy,
    input  logic                                   grid_res_vld,
    input  logic                                   grid_occupied
);

    localparam int W  = GRID_WIDTH_LOG2;
    localparam int H  = GRID_HEIGHT_LOG2;
    localparam int MW = (W > H) ? W : H;
    localparam int CW = MW + 1;   // cell counter width
    localparam int AW = MW + 2;   // signed Bresenham arithmetic width

    localparam logic [W-1:0]         c_one_x = W'(1);
    localparam logic [H-1:0]         c_one_y = H'(1);
    localparam logic [CW-1:0]        c_one_c = CW'(1);
    localparam logic signed [AW-1:0] c_zero  = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Walk state
    logic [W-1:0]         r_x;
    logic [H-1:0]         r_y;
    logic [W-1:0]         r_x1;
    logic [H-1:0]         r_y1;
    logic                 r_sx_neg;
    logic                 r_sy_neg;
    logic signed [AW-1:0] r_dx;
    logic signed [AW-1:0] r_dy;
    logic signed [AW-1:0] r_err;
    logic                 r_collision;
    logic [CW-1:0]        r_cnt;

    // ------------------------------------------------------------------
    // Request-time setup: endpoints zero-extended into the signed domain
    // so that the absolute differences never overflow.
    // ------------------------------------------------------------------
    logic signed [AW-1:0] w_x0e;
    logic signed [AW-1:0] w_x1e;
    logic signed [AW-1:0] w_y0e;
    logic signed [AW-1:0] w_y1e;
    logic signed [AW-1:0] w_dx_req;
    logic signed [AW-1:0] w_dy_abs;
    logic signed [AW-1:0] w_dy_req;

    assign w_x0e    = $signed({{(AW-W){1'b0}}, x0_in});
    assign w_x1e    = $signed({{(AW-W){1'b0}}, x1_in});
    assign w_y0e    = $signed({{(AW-H){1'b0}}, y0_in});
    assign w_y1e    = $signed({{(AW-H){1'b0}}, y1_in});
    assign w_dx_req = (w_x1e >= w_x0e) ? (w_x1e - w_x0e) : (w_x0e - w_x1e);
    assign w_dy_abs = (w_y1e >= w_y0e) ? (w_y1e - w_y0e) : (w_y0e - w_y1e);
    assign w_dy_req = c_zero - w_dy_abs;

    // ------------------------------------------------------------------
    // Step decision. e2 = 2*err is one bit wider so the doubling is exact.
    // ------------------------------------------------------------------
    logic signed [AW:0]   w_e2;
    logic signed [AW:0]   w_dx_ext;
    logic signed [AW:0]   w_dy_ext;
    logic                 w_step_x;
    logic                 w_step_y;
    logic signed [AW-1:0] w_inc_x;
    logic signed [AW-1:0] w_inc_y;
    logic signed [AW-1:0] w_err_step;

    assign w_e2       = $signed({r_err, 1'b0});
    assign w_dx_ext   = $signed({r_dx[AW-1], r_dx});
    assign w_dy_ext   = $signed({r_dy[AW-1], r_dy});
    assign w_step_x   = (w_e2 >= w_dy_ext);
    assign w_step_y   = (w_e2 <= w_dx_ext);
    assign w_inc_x    = w_step_x ? r_dy : c_zero;
    assign w_inc_y    = w_step_y ? r_dx : c_zero;
    // A diagonal step takes both increments.
    assign w_err_step = r_err + w_inc_x + w_inc_y;

    logic w_at_end;
    logic w_early;

    assign w_at_end = (r_x == r_x1) && (r_y == r_y1);

`ifdef LINE_CHECK_EARLY_EXIT_EN
    assign w_early = grid_occupied;
`else
    assign w_early = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        req_rdy      = 1'b0;
        res_vld      = 1'b0;
        grid_vld     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_rdy = 1'b1;
                if (req_vld) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                grid_vld = 1'b1;
                if (grid_rdy) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (grid_res_vld) begin
                    if (w_at_end || w_early) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_STEP;
                    end
                end
            end
            S_STEP: begin
                w_state_next = S_ISSUE;
            end
            S_DONE: begin
                res_vld = 1'b1;
                if (res_rdy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_sx_neg    <= 1'b0;
            r_sy_neg    <= 1'b0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_err       <= '0;
            r_collision <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_vld) begin
                        r_x         <= x0_in;
                        r_y         <= y0_in;
                        r_x1        <= x1_in;
                        r_y1        <= y1_in;
                        r_sx_neg    <= (x1_in < x0_in);
                        r_sy_neg    <= (y1_in < y0_in);
                        r_dx        <= w_dx_req;
                        r_dy        <= w_dy_req;
                        r_err       <= w_dx_req + w_dy_req;
                        r_collision <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                S_WAIT: begin
                    if (grid_res_vld) begin
                        r_cnt       <= r_cnt + c_one_c;
                        r_collision <= r_collision | grid_occupied;
                    end
                end
                S_STEP: begin
                    // Bresenham never steps past the end point, so the
                    // coordinates stay inside the endpoint bounding box.
                    r_err <= w_err_step;
                    if (w_step_x) begin
                        r_x <= r_sx_neg ? (r_x - c_one_x) : (r_x + c_one_x);
                    end
                    if (w_step_y) begin
                        r_y <= r_sy_neg ? (r_y - c_one_y) : (r_y + c_one_y);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cell_x_out    = r_x;
    assign cell_y_out    = r_y;
    assign grid_we       = 1'b0;
    assign collision     = r_collision;
    assign cells_checked = r_cnt;

endmodule
`default_nettype wire

// File: doc/line_collision_checker.md
# line_collision_checker

Walks the grid cells on the straight segment between two cell coordinates using integer Bresenham stepping. Issues one read query per cell to the occupancy grid and reports whether any visited cell is occupied. Sits directly upstream of `occupancy_grid`: drives its `cell_x_in`/`cell_y_in`/`vld_in` and consumes `rdy`/`vld_out`/`r_occupied`. Used by the RRT extend step to validate a candidate edge.

## Interface
- `GRID_WIDTH_LOG2`, 8, x cell coordinate width (W).
- `GRID_HEIGHT_LOG2`, 8, y cell coordinate width (H).
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_vld` in 1: segment request valid.
- `req_rdy` out 1: checker idle, can accept a request.
- `x0_in`, `x1_in` in W: segment start/end x.
- `y0_in`, `y1_in` in H: segment start/end y.
- `res_vld` out 1: result valid; held until accepted.
- `res_rdy` in 1: consumer accepts result.
- `collision` out 1: 1 = at least one visited cell occupied.
- `cells_checked` out max(W,H)+1: grid queries completed for this segment.
- `cell_x_out` out W, `cell_y_out` out H: to grid `cell_x_in`/`cell_y_in`.
- `grid_vld` out 1: to grid `vld_in`; `grid_we` out 1: tied 0.
- `grid_rdy` in 1: from grid `rdy`.
- `grid_res_vld` in 1: from grid `vld_out`; `grid_occupied` in 1: from grid `r_occupied`.

## Operation
- States: IDLE, ISSUE, WAIT, STEP, DONE.
- IDLE: `req_rdy`=1. On `req_vld`: latch endpoints; x=x0, y=y0; dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1 toward end; err=dx+dy; clear `collision`, `cells_checked`; -> ISSUE.
- Arithmetic: dx, dy, err signed, width max(W,H)+2; e2=2*err computed one bit wider. No coordinate ever leaves [min,max] of its endpoints; no wrap.
- ISSUE: `grid_vld`=1, cell outputs = (x,y). On `grid_vld && grid_rdy` -> WAIT. Requests and outputs held stable while `grid_rdy`=0.
- WAIT: one query outstanding; `grid_vld`=0. On `grid_res_vld`: `cells_checked`++, `collision` |= `grid_occupied`. Then, if current cell == (x1,y1), or early exit applies (Configuration) -> DONE; else -> STEP.
- STEP: if e2>=dy: err+=dy, x+=sx; if e2<=dx: err+=dx, y+=sy (both may apply: diagonal step, err gets both increments). -> ISSUE.
- DONE: `res_vld`=1; on `res_rdy` -> IDLE. `collision`/`cells_checked` hold until next request accepted.
- Degenerate segment (x0==x1, y0==y1): exactly one query, `cells_checked`=1.
- `grid_res_vld` outside WAIT ignored. `req_vld` outside IDLE ignored (not latched).
- Reset (any time, including mid-walk or with a query outstanding): state IDLE, all outputs 0 except `req_rdy`=1; a pending grid response after reset is ignored.

## Timing
- Request accepted cycle 0 -> `grid_vld` high cycle 1.
- Per cell: 1 cycle ISSUE (if `grid_rdy`) + grid latency L in WAIT + 1 cycle STEP. For L=1: 3 cycles/cell.
- Last response cycle t -> `res_vld` high cycle t+1.
- Total for N cells, L=1, `grid_rdy` always 1: 3N cycles from accept to `res_vld`.
- `res_vld && res_rdy` cycle t -> `req_rdy` high cycle t+1; back-to-back requests lose one cycle.

## Configuration
- `LINE_CHECK_EARLY_EXIT_EN` defined: WAIT -> DONE on first occupied response; `cells_checked` = index of first occupied cell +1.
- Not defined: full segment always walked; `collision` is OR over all cells; `cells_checked` = max(dx,|dy|)+1.

## Test plan
- Reset mid-walk: assert `rst_n`=0 in WAIT -> next cycle `grid_vld`=0, `res_vld`=0, `req_rdy`=1; fresh request afterwards completes normally.
- Empty grid, (0,0)->(5,2) -> cells (0,0),(1,0),(2,1),(3,1),(4,2),(5,2) queried in order; `collision`=0, `cells_checked`=6; `res_vld` at cycle 18 with L=1.
- Occupied (3,3), segment (0,0)->(7,7) -> `collision`=1; `cells_checked`=4 with EARLY_EXIT_EN, 8 without.
- Reverse/steep: (9,1)->(8,6) -> y steps 1..6, x moves to 8 exactly once; 6 queries; last cell (8,6).
- Degenerate (4,4)->(4,4), cell occupied -> one query, `collision`=1, `cells_checked`=1.
- Backpressure: hold `grid_rdy`=0 10 cycles in ISSUE -> `grid_vld` and cell outputs stable; `res_rdy`=0 for 5 cycles in DONE -> `res_vld`, `collision` held, `req_rdy`=0.
